// File: rtl/ga_sync_irq_if.sv
// Bus bundle between the CRTC-side stimulus and the Gate Array sync/interrupt stage.
// master drives the CRTC sync, Z80 acknowledge and RMR write; slave returns the sync and interrupt outputs.
interface ga_sync_irq_if;
    logic       CLKEN;
    logic       HSYNC_I;
    logic       VSYNC_I;
    logic       IRQ_ACK;
    logic       RMR_WR;
    logic [7:0] RMR_DI;
    logic       INT;
    logic       HSYNC_O;
    logic       VSYNC_O;
    logic [1:0] MODE;
    logic       CSYNC;

    modport master (
        output CLKEN, HSYNC_I, VSYNC_I, IRQ_ACK, RMR_WR, RMR_DI,
        input  INT, HSYNC_O, VSYNC_O, MODE, CSYNC
    );

    modport slave (
        input  CLKEN, HSYNC_I, VSYNC_I, IRQ_ACK, RMR_WR, RMR_DI,
        output INT, HSYNC_O, VSYNC_O, MODE, CSYNC
    );
endinterface

// File: rtl/ga_sync_irq.sv
// Gate Array sync/interrupt stage: monitor HSYNC/VSYNC, 52-line raster interrupt with VSYNC resync, latched MODE.
// Define GA_CSYNC_EN to build the registered composite sync output; otherwise CSYNC is tied low.
module ga_sync_irq #(
    parameter int INT_LINES = 52,
    parameter int VS_DELAY  = 2,
    parameter int VS_LEN    = 4
) (
    input  logic          CLOCK,
    input  logic          nRESET,
    ga_sync_irq_if.slave  bus
);
    localparam int DW = (VS_DELAY < 1) ? 1 : $clog2(VS_DELAY + 1);
    localparam int LW = (VS_LEN   < 1) ? 1 : $clog2(VS_LEN + 1);

    logic [3:0]    hsc_q, hsc_d;
    logic [5:0]    r52_q, r52_d;
    logic [DW-1:0] vs_delay_q, vs_delay_d;
    logic [LW-1:0] vs_cnt_q, vs_cnt_d;
    logic [1:0]    mode_pend_q, mode_pend_d;
    logic [1:0]    mode_q, mode_d;
    logic          hs_prev_q, hs_prev_d;
    logic          vs_prev_q, vs_prev_d;
    logic          int_q, int_d;
    logic          hsync_o_q, hsync_o_d;
    logic          vsync_o_q, vsync_o_d;
    logic          hs_fall, vs_rise, int_set;
    logic          unused_rmr_bits;

    assign unused_rmr_bits = ^{bus.RMR_DI[7:5], bus.RMR_DI[3:2]};

    assign hs_fall = bus.CLKEN & hs_prev_q & ~bus.HSYNC_I;
    assign vs_rise = bus.CLKEN & ~vs_prev_q & bus.VSYNC_I;

    always_comb begin
        hsc_d       = hsc_q;
        r52_d       = r52_q;
        vs_delay_d  = vs_delay_q;
        vs_cnt_d    = vs_cnt_q;
        mode_pend_d = mode_pend_q;
        mode_d      = mode_q;
        hs_prev_d   = hs_prev_q;
        vs_prev_d   = vs_prev_q;
        int_d       = int_q;
        hsync_o_d   = hsync_o_q;
        vsync_o_d   = vsync_o_q;
        int_set     = 1'b0;

        if (bus.CLKEN) begin
            hs_prev_d = bus.HSYNC_I;
            vs_prev_d = bus.VSYNC_I;
            if (!bus.HSYNC_I)
                hsc_d = 4'd0;
            else if (hsc_q != 4'hF)
                hsc_d = hsc_q + 4'd1;
            // 4-character pulse delayed by 2 characters, cut short if the CRTC pulse ends first
            hsync_o_d = bus.HSYNC_I && (hsc_q >= 4'd2) && (hsc_q <= 4'd5);
            if (hsync_o_d && !hsync_o_q)
                mode_d = mode_pend_q;
        end

        if (hs_fall) begin
            if (vs_cnt_q != '0) begin
                vs_cnt_d = vs_cnt_q - LW'(1);
                if (vs_cnt_q == LW'(1))
                    vsync_o_d = 1'b0;
            end
            if (vs_delay_q == DW'(1)) begin
                // VSYNC resync: the line counter restarts instead of counting this line
                int_set    = r52_q[5];
                r52_d      = 6'd0;
                vs_delay_d = '0;
                vsync_o_d  = 1'b1;
                vs_cnt_d   = LW'(VS_LEN);
            end else begin
                if (vs_delay_q != '0)
                    vs_delay_d = vs_delay_q - DW'(1);
                if (r52_q == 6'(INT_LINES - 1)) begin
                    r52_d   = 6'd0;
                    int_set = 1'b1;
                end else begin
                    r52_d = r52_q + 6'd1;
                end
            end
        end

        if (vs_rise)
            vs_delay_d = DW'(VS_DELAY);

        // An acknowledge losing to a same-edge set leaves INT high and r52 already cleared
        if (bus.IRQ_ACK && !int_set) begin
            int_d    = 1'b0;
            r52_d[5] = 1'b0;
        end
        if (int_set)
            int_d = 1'b1;

        if (bus.RMR_WR) begin
            mode_pend_d = bus.RMR_DI[1:0];
            if (bus.RMR_DI[4]) begin
                r52_d = 6'd0;
                int_d = 1'b0;
            end
        end
    end

    always_ff @(posedge CLOCK) begin
        if (!nRESET) begin
            hsc_q       <= 4'd0;
            r52_q       <= 6'd0;
            vs_delay_q  <= '0;
            vs_cnt_q    <= '0;
            mode_pend_q <= 2'd1;
            mode_q      <= 2'd1;
            hs_prev_q   <= 1'b0;
            vs_prev_q   <= 1'b0;
            int_q       <= 1'b0;
            hsync_o_q   <= 1'b0;
            vsync_o_q   <= 1'b0;
        end else begin
            hsc_q       <= hsc_d;
            r52_q       <= r52_d;
            vs_delay_q  <= vs_delay_d;
            vs_cnt_q    <= vs_cnt_d;
            mode_pend_q <= mode_pend_d;
            mode_q      <= mode_d;
            hs_prev_q   <= hs_prev_d;
            vs_prev_q   <= vs_prev_d;
            int_q       <= int_d;
            hsync_o_q   <= hsync_o_d;
            vsync_o_q   <= vsync_o_d;
        end
    end

`ifdef GA_CSYNC_EN
    logic csync_q;

    // XOR gives inverted horizontal serrations while VSYNC_O is active
    always_ff @(posedge CLOCK) begin
        if (!nRESET)
            csync_q <= 1'b0;
        else
            csync_q <= hsync_o_q ^ vsync_o_q;
    end

    assign bus.CSYNC = csync_q;
`else
    assign bus.CSYNC = 1'b0;
`endif

    assign bus.INT     = int_q;
    assign bus.HSYNC_O = hsync_o_q;
    assign bus.VSYNC_O = vsync_o_q;
    assign bus.MODE    = mode_q;
endmodule

// File: tb/tb_ga_sync_irq.sv
// Scoreboard bench for ga_sync_irq: stimulus pushes model predictions, a posedge+1 monitor pops and compares.
// The reference model tracks characters, lines and pending-VSYNC counts as plain integers.
module tb_ga_sync_irq;
    localparam int INT_LINES  = 52;
    localparam int VS_DELAY   = 2;
    localparam int VS_LEN     = 4;
    localparam int LINE_CHARS = 20;

    logic CLOCK  = 1'b0;
    logic nRESET = 1'b0;
    always #5 CLOCK = ~CLOCK;

    ga_sync_irq_if bus ();

    ga_sync_irq #(.INT_LINES(INT_LINES), .VS_DELAY(VS_DELAY), .VS_LEN(VS_LEN)) dut (
        .CLOCK  (CLOCK),
        .nRESET (nRESET),
        .bus    (bus)
    );

    typedef struct {
        bit       irq;
        bit       hso;
        bit       vso;
        bit [1:0] mode;
        bit       csync;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   lines_done  = 0;

    // Reference model state
    int       m_run;      // consecutive characters HSYNC_I has been high
    int       m_lines;    // lines counted since last interrupt/resync
    int       m_wait;     // HSYNC falls still to go before VSYNC resync
    int       m_vleft;    // remaining VSYNC_O lines
    bit       m_hs_prev, m_vs_prev;
    bit       m_int, m_hso, m_vso, m_csync;
    bit [1:0] m_mode, m_pend;

    task automatic model_update(bit rst, bit ce, bit hs, bit vs, bit ack, bit rmr, bit [7:0] di);
        bit set, fall, rise, new_hso;
        int lines;
        if (rst) begin
            m_run = 0; m_lines = 0; m_wait = 0; m_vleft = 0;
            m_hs_prev = 0; m_vs_prev = 0;
            m_int = 0; m_hso = 0; m_vso = 0; m_csync = 0;
            m_mode = 2'd1; m_pend = 2'd1;
            return;
        end
`ifdef GA_CSYNC_EN
        m_csync = m_hso ^ m_vso;
`else
        m_csync = 1'b0;
`endif
        set   = 1'b0;
        lines = m_lines;
        if (ce) begin
            fall    = m_hs_prev && !hs;
            rise    = !m_vs_prev && vs;
            new_hso = hs && (m_run >= 2) && (m_run <= 5);
            if (new_hso && !m_hso) m_mode = m_pend;
            m_hso = new_hso;
            if (fall) begin
                if (m_vleft > 0) begin
                    m_vleft--;
                    if (m_vleft == 0) m_vso = 1'b0;
                end
                if (m_wait == 1) begin
                    set     = (lines >= 32);
                    lines   = 0;
                    m_wait  = 0;
                    m_vso   = 1'b1;
                    m_vleft = VS_LEN;
                end else begin
                    if (m_wait > 0) m_wait--;
                    lines++;
                    if (lines == INT_LINES) begin
                        lines = 0;
                        set   = 1'b1;
                    end
                end
            end
            if (rise) m_wait = VS_DELAY;
            m_run     = hs ? ((m_run < 100) ? m_run + 1 : m_run) : 0;
            m_hs_prev = hs;
            m_vs_prev = vs;
        end
        if (ack && !set) begin
            m_int = 1'b0;
            if (lines >= 32) lines -= 32;
        end
        if (set) m_int = 1'b1;
        if (rmr) begin
            m_pend = di[1:0];
            if (di[4]) begin
                lines = 0;
                m_int = 1'b0;
            end
        end
        m_lines = lines;
    endtask

    task automatic step(bit rst, bit ce, bit hs, bit vs, bit ack, bit rmr, bit [7:0] di);
        exp_t e;
        @(negedge CLOCK);
        nRESET      = !rst;
        bus.CLKEN   = ce;
        bus.HSYNC_I = hs;
        bus.VSYNC_I = vs;
        bus.IRQ_ACK = ack;
        bus.RMR_WR  = rmr;
        bus.RMR_DI  = di;
        model_update(rst, ce, hs, vs, ack, rmr, di);
        e.irq = m_int; e.hso = m_hso; e.vso = m_vso; e.mode = m_mode; e.csync = m_csync;
        exp_q.push_back(e);
    endtask

    task automatic idle_cycle(bit rand_ev, bit hs, bit vs);
        bit       ack, rmr;
        bit [7:0] di;
        ack = rand_ev && m_int && ($urandom_range(0, 5) == 0);
        rmr = rand_ev && ($urandom_range(0, 39) == 0);
        di  = {3'b000, ($urandom_range(0, 7) == 0), 2'b00, 2'($urandom_range(0, 3))};
        step(0, 0, hs, vs, ack, rmr, rmr ? di : 8'h00);
    endtask

    // One scan line: HSYNC_I high for hs_len characters; fall_rmr >= 0 writes RMR on the HSYNC fall
    task automatic do_line(int hs_len, bit vs, bit rand_ev, int fall_rmr);
        bit hs, ack, rmr;
        int idle;
        for (int c = 0; c < LINE_CHARS; c++) begin
            hs   = (c < hs_len);
            idle = $urandom_range(0, 1);
            for (int i = 0; i < idle; i++) idle_cycle(rand_ev, hs, vs);
            rmr = (fall_rmr >= 0) && (hs_len > 0) && (c == hs_len);
            ack = rand_ev && m_int && ($urandom_range(0, 9) == 0);
            step(0, 1, hs, vs, ack, rmr, rmr ? 8'(fall_rmr) : 8'h00);
        end
        lines_done++;
        $display("line %0d: hs_len=%0d vs=%0d int=%0d vso=%0d mode=%0d", lines_done, hs_len, vs, m_int, m_vso, m_mode);
    endtask

    task automatic ack_now();
        step(0, 0, 0, 0, 1, 0, 8'h00);
    endtask

    task automatic wait_lines(int target);
        int n;
        n = 0;
        while (m_lines != target && n < 120) begin
            do_line(6, 0, 0, -1);
            n++;
        end
        if (m_lines != target) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_lines: line count %0d, required %0d within bound", m_lines, target);
        end
    endtask

    // Monitor: compares one registered output set per CLOCK, after the edge settles
    initial begin
        exp_t e;
        forever begin
            @(posedge CLOCK);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                if (bus.INT !== e.irq || bus.HSYNC_O !== e.hso || bus.VSYNC_O !== e.vso ||
                    bus.MODE !== e.mode || bus.CSYNC !== e.csync) begin
                    miscompares++;
                    $display("FAIL outputs @%0t: INT/HS/VS/MODE/CS got %b/%b/%b/%0d/%b required %b/%b/%b/%0d/%b",
                             $time, bus.INT, bus.HSYNC_O, bus.VSYNC_O, bus.MODE, bus.CSYNC,
                             e.irq, e.hso, e.vso, e.mode, e.csync);
                end
            end
        end
    end

    initial begin
        bit vs_on;
        int vs_lines, gap;
        bus.CLKEN = 0; bus.HSYNC_I = 0; bus.VSYNC_I = 0;
        bus.IRQ_ACK = 0; bus.RMR_WR = 0; bus.RMR_DI = 8'h00;

        repeat (3) step(1, 0, 0, 0, 0, 0, 8'h00);

        // HSYNC_O shaping: 14, 3 and 2 character input pulses
        do_line(14, 0, 0, -1);
        do_line(3, 0, 0, -1);
        do_line(2, 0, 0, -1);

        // Free-running 52-line interrupt, then acknowledge
        wait_lines(INT_LINES - 1);
        do_line(6, 0, 0, -1);
        ack_now();

        // VSYNC resync with counter past 32 and below 32
        wait_lines(40);
        do_line(6, 1, 0, -1);
        repeat (6) do_line(6, 1, 0, -1);
        repeat (2) do_line(6, 0, 0, -1);
        ack_now();
        wait_lines(20);
        repeat (5) do_line(6, 1, 0, -1);
        repeat (4) do_line(6, 0, 0, -1);

        // Acknowledge clears bit 5 of the line counter
        wait_lines(40);
        ack_now();
        repeat (46) do_line(6, 0, 0, -1);
        ack_now();

        // Interrupt reset via RMR on the 52nd fall, then a deferred mode change
        wait_lines(INT_LINES - 1);
        do_line(6, 0, 0, 8'h10);
        step(0, 0, 0, 0, 0, 1, 8'h02);
        repeat (3) do_line(8, 0, 0, -1);

        // Reset during VSYNC_O with INT pending
        wait_lines(45);
        repeat (2) do_line(6, 1, 0, -1);
        step(0, 1, 1, 1, 0, 0, 8'h00);
        repeat (2) step(1, 0, 0, 0, 0, 0, 8'h00);
        repeat (2) do_line(6, 0, 0, -1);

        // Randomized traffic: varied pulse widths, VSYNC bursts, acks and RMR writes
        vs_on = 0; vs_lines = 0; gap = $urandom_range(20, 70);
        for (int l = 0; l < 400; l++) begin
            if (!vs_on && gap == 0) begin
                vs_on = 1; vs_lines = $urandom_range(1, 6);
            end else if (vs_on && vs_lines == 0) begin
                vs_on = 0; gap = $urandom_range(20, 70);
            end
            if (vs_on) vs_lines--; else gap--;
            do_line($urandom_range(0, 14), vs_on, 1,
                    ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 31)) : -1);
        end

        repeat (3) @(negedge CLOCK);
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: %0d predictions left unchecked, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ga_sync_irq.md
# ga_sync_irq

Gate Array sync and interrupt stage, directly downstream of the CRTC. It consumes the CRTC's raw HSYNC/VSYNC at character rate and produces the monitor HSYNC/VSYNC and the Z80 raster interrupt (52-line counter with VSYNC resynchronisation). It also produces the HSYNC-latched screen mode. Output feeds the video DAC/scan path and the CPU interrupt input.

## Interface
Parameters:
- INT_LINES, 52, HSYNC falls per interrupt
- VS_DELAY, 2, HSYNC falls from VSYNC_I rise to counter resync / VSYNC_O start
- VS_LEN, 4, VSYNC_O length in HSYNC falls

Ports:
- CLOCK  in  1  system clock
- nRESET  in  1  reset, synchronous, active-low
- CLKEN  in  1  character-clock enable (same enable that drives the CRTC)
- HSYNC_I  in  1  CRTC HSYNC
- VSYNC_I  in  1  CRTC VSYNC
- IRQ_ACK  in  1  one-CLOCK pulse, Z80 interrupt acknowledge
- RMR_WR  in  1  one-CLOCK pulse, RMR register write
- RMR_DI  in  8  RMR data: [4] interrupt reset, [1:0] requested mode
- INT  out  1  interrupt request, active-high, level
- HSYNC_O  out  1  monitor horizontal sync
- VSYNC_O  out  1  monitor vertical sync
- MODE  out  2  active screen mode
- CSYNC  out  1  composite sync (see Configuration)

## Operation
- Reset values: INT=0, HSYNC_O=0, VSYNC_O=0, MODE=1, CSYNC=0; internal hsc=0, r52=0, vs_delay=0, vs_cnt=0, mode_pend=1, hs_prev=0, vs_prev=0.
- All counters advance only on CLKEN; IRQ_ACK and RMR_WR act on any CLOCK edge.
- hsc (4-bit): HSYNC_I=1 → hsc+1 saturating at 15; HSYNC_I=0 → 0.
- HSYNC_O <= HSYNC_I & (2 ≤ hsc ≤ 5): 4 characters, 2-character delay, truncated if HSYNC_I ends earlier; absent if HSYNC_I is shorter than 3 characters.
- MODE <= mode_pend on the CLKEN where HSYNC_O goes 0→1.
- hs_fall = CLKEN & hs_prev & ~HSYNC_I; vs_rise = CLKEN & ~vs_prev & VSYNC_I.
- vs_rise: vs_delay <= VS_DELAY.
- On hs_fall, if vs_delay==1, resync: r52<=0, INT<=1 when r52≥32, vs_delay<=0, VSYNC_O<=1, vs_cnt<=VS_LEN. The normal increment is replaced.
- Otherwise, on hs_fall: vs_delay decrements if nonzero. If r52==INT_LINES-1 → r52<=0, INT<=1; else r52+1.
- On hs_fall with vs_cnt≠0: vs_cnt-1; VSYNC_O<=0 when it reaches 0. VSYNC_O is independent of VSYNC_I fall.
- IRQ_ACK: INT<=0, r52[5]<=0.
- RMR_WR: mode_pend<=RMR_DI[1:0]. If RMR_DI[4]: r52<=0, INT<=0.
- Priority, same CLOCK: nRESET > RMR_WR reset > INT set (wrap/resync) > IRQ_ACK. An ack coinciding with a set leaves INT=1, r52=0.
- vs_rise during an active vs_delay restarts it at VS_DELAY.

## Timing
- HSYNC_I first sampled 1 at CLKEN edge k: HSYNC_O rises at CLKEN edge k+2 and falls at k+6, or at the first CLKEN edge sampling HSYNC_I=0, whichever is earlier.
- INT rises 1 CLOCK after the qualifying hs_fall CLKEN edge. It falls 1 CLOCK after IRQ_ACK/RMR_WR.
- VSYNC_O rises with the resync hs_fall and lasts VS_LEN lines.
- CSYNC is registered: 1 CLOCK after HSYNC_O/VSYNC_O.
- No CLKEN → no counter or output change except IRQ_ACK/RMR_WR effects.

## Configuration
- GA_CSYNC_EN defined: CSYNC <= HSYNC_O ^ VSYNC_O, giving inverted serrations during vertical sync.
- GA_CSYNC_EN undefined: CSYNC tied 0 and no CSYNC register is built.

## Test plan
- HSYNC_I high 14 chars → HSYNC_O high exactly chars 2..5 (4 CLKENs); HSYNC_I high 3 chars → HSYNC_O high 1 CLKEN; 2 chars → never.
- 52 HSYNC pulses, no VSYNC → INT rises after the 52nd fall, r52=0; IRQ_ACK → INT=0.
- VSYNC_I rise with r52=40 → after 2nd following hs_fall: INT=1, r52=0, VSYNC_O=1 for 4 lines. Repeat with r52=20 → INT stays 0, r52=0.
- r52=40 (bit5 set), IRQ_ACK → r52=8, INT=0; next interrupt 44 lines later.
- RMR_WR 0x10 coinciding with the 52nd hs_fall → INT=0, r52=0. RMR_WR 0x02 → MODE=2 only at next HSYNC_O rise.
- nRESET mid-VSYNC_O with INT=1 → all outputs at reset values next CLOCK, MODE=1.
